// File: rtl/div_timer_if.sv
// div_timer_if: register bus and per-channel irq lines of div_timer
interface div_timer_if #(
  parameter int CNT_W  = 8,
  parameter int NCH    = 1,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic              rd;
  logic [CNT_W-1:0]  wdata;
  logic [CNT_W-1:0]  rdata;
  logic [NCH-1:0]    irq;
  modport master (output addr, wr, rd, wdata, input rdata, irq);
  modport slave  (input addr, wr, rd, wdata, output rdata, irq);
endinterface

// File: rtl/div_timer.sv
// div_timer: free-running divider with NCH timer channels counting falling edges of divider taps
module div_timer #(
  parameter int          DIV_W = 16,
  parameter int          CNT_W = 8,
  parameter int          NCH   = 1,
  parameter logic [15:0] TAPS  = 16'h7539
) (
  input logic         clk,
  input logic         nreset,
  input logic         ce,
  div_timer_if.slave  bus
);
  localparam int ADDR_W = $clog2(1 + 3 * NCH);
  typedef enum logic {RUN, OVF} st_e;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] count_q [NCH];
  logic [CNT_W-1:0] count_d [NCH];
  logic [CNT_W-1:0] modulo_q [NCH];
  logic [CNT_W-1:0] modulo_d [NCH];
  logic [2:0]       ctrl_q [NCH];
  logic [2:0]       ctrl_d [NCH];
  st_e              st_q [NCH];
  st_e              st_d [NCH];
  logic [NCH-1:0]   sig_q, sig_d, irq_q, irq_d;
  logic [CNT_W-1:0] rdata_q, rdata_d, rd_val;
  logic [3:0]       tap;
  always_comb begin
    div_d    = (bus.wr && bus.addr == '0) ? '0 : ce ? div_q + 1'b1 : div_q;
    rd_val   = (bus.addr == '0) ? div_q[DIV_W-1 -: CNT_W] : '0;
    count_d  = count_q;
    modulo_d = modulo_q;
    ctrl_d   = ctrl_q;
    st_d     = st_q;
    irq_d    = '0;
    sig_d    = '0;
    tap      = '0;
    for (int i = 0; i < NCH; i++) begin
      tap      = TAPS[4 * ctrl_q[i][1:0] +: 4];
      sig_d[i] = ctrl_q[i][2] & div_q[tap];
      if (bus.wr && bus.addr == ADDR_W'(3 * i + 2)) modulo_d[i] = bus.wdata;
      if (bus.wr && bus.addr == ADDR_W'(3 * i + 3)) ctrl_d[i] = bus.wdata[2:0];
      if (bus.wr && bus.addr == ADDR_W'(3 * i + 1)) begin
        count_d[i] = bus.wdata;
        st_d[i]    = RUN;
      end else if (st_q[i] == OVF) begin
        if (ce) begin
          count_d[i] = modulo_d[i];
          irq_d[i]   = 1'b1;
          st_d[i]    = RUN;
        end
      end else if (sig_q[i] && !sig_d[i]) begin
        count_d[i] = count_q[i] + 1'b1;
        st_d[i]    = (&count_q[i]) ? OVF : RUN;
      end
      if (bus.addr == ADDR_W'(3 * i + 1)) rd_val = count_q[i];
      if (bus.addr == ADDR_W'(3 * i + 2)) rd_val = modulo_q[i];
      if (bus.addr == ADDR_W'(3 * i + 3)) rd_val = CNT_W'(ctrl_q[i]);
    end
    rdata_d = bus.rd ? rd_val : rdata_q;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_q   <= '0;
      sig_q   <= '0;
      irq_q   <= '0;
      rdata_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        count_q[i]  <= '0;
        modulo_q[i] <= '0;
        ctrl_q[i]   <= '0;
        st_q[i]     <= RUN;
      end
    end else begin
      div_q    <= div_d;
      sig_q    <= sig_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      count_q  <= count_d;
      modulo_q <= modulo_d;
      ctrl_q   <= ctrl_d;
      st_q     <= st_d;
    end
  end
  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;
endmodule

// File: tb/tb_div_timer.sv
// tb_div_timer: scoreboard bench for div_timer with two channels
module tb_div_timer;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic ce = 1'b0;
  always #5 clk = ~clk;
  div_timer_if #(.CNT_W(8), .NCH(2), .ADDR_W(3)) bus ();
  div_timer #(.NCH(2)) dut (.clk(clk), .nreset(nreset), .ce(ce), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  int ic0 = 0;
  int ic1 = 0;
  int both = 0;
  int b0, b1, bb;
  logic rd_seen = 1'b0;
  logic [7:0] exp_q [$];
  string tag_q [$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) rd_seen <= bus.rd;
  always @(negedge clk) begin
    if (bus.irq[0]) ic0++;
    if (bus.irq[1]) ic1++;
    if (bus.irq == 2'b11) both++;
    if (rd_seen) begin
      if (exp_q.size() == 0) chk("sb_empty", 32'(exp_q.size()), 32'd1);
      else chk(tag_q.pop_front(), 32'(bus.rdata), 32'(exp_q.pop_front()));
    end
  end
  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.wdata = d;
    bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask
  task automatic rd_reg(input logic [2:0] a, input logic [7:0] e, input string t);
    @(negedge clk);
    bus.addr = a;
    bus.rd = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(negedge clk);
    bus.rd = 1'b0;
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
    end
    @(posedge clk);
  endtask
  initial begin
    bus.addr = '0;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    nreset = 1'b1;
    rd_reg(1, 8'h00, "rst_count0");
    rd_reg(3, 8'h00, "rst_ctrl0");
    tick(256);
    rd_reg(0, 8'h01, "div_256");
    repeat (2) @(negedge clk);
    chk("rdata_hold", 32'(bus.rdata), 32'd1);
    wr_reg(0, 8'hAB);
    rd_reg(0, 8'h00, "div_clear");
    wr_reg(3, 8'h05);
    wr_reg(2, 8'hF0);
    wr_reg(1, 8'hFF);
    b0 = ic0;
    tick(16);
    rd_reg(1, 8'h00, "ovf_count");
    chk("ovf_no_irq_yet", 32'(ic0 - b0), 32'd0);
    tick(1);
    chk("ovf_irq", 32'(ic0 - b0), 32'd1);
    rd_reg(1, 8'hF0, "ovf_reload");
    wr_reg(1, 8'hFF);
    wr_reg(0, 8'h00);
    tick(16);
    rd_reg(1, 8'h00, "cancel_ovf");
    wr_reg(1, 8'h42);
    b0 = ic0;
    tick(1);
    chk("cancel_irq", 32'(ic0 - b0), 32'd0);
    rd_reg(1, 8'h42, "cancel_count");
    tick(7);
    wr_reg(0, 8'h00);
    rd_reg(1, 8'h43, "glitch_inc");
    wr_reg(2, 8'h77);
    wr_reg(5, 8'h33);
    wr_reg(1, 8'hFF);
    wr_reg(4, 8'hFF);
    wr_reg(6, 8'h05);
    rd_reg(6, 8'h05, "ctrl1");
    wr_reg(7, 8'h5A);
    rd_reg(7, 8'h00, "unmapped");
    wr_reg(0, 8'h00);
    b0 = ic0;
    b1 = ic1;
    bb = both;
    tick(16);
    rd_reg(4, 8'h00, "ovf_ch1");
    tick(1);
    chk("both_irq", 32'(both - bb), 32'd1);
    chk("irq0", 32'(ic0 - b0), 32'd1);
    chk("irq1", 32'(ic1 - b1), 32'd1);
    rd_reg(1, 8'h77, "reload0");
    rd_reg(4, 8'h33, "reload1");
    rd_reg(2, 8'h77, "modulo0");
    wr_reg(1, 8'hFF);
    wr_reg(0, 8'h00);
    tick(16);
    rd_reg(4, 8'h34, "pre_rst_ch1");
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("midrst_irq", 32'(bus.irq), 32'd0);
    chk("midrst_rdata", 32'(bus.rdata), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    b0 = ic0;
    rd_reg(1, 8'h00, "midrst_count");
    tick(4);
    chk("midrst_no_irq", 32'(ic0 - b0), 32'd0);
    rd_reg(1, 8'h00, "midrst_count_after");
    @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
